// File: rtl/bcd_tick_counter.sv
// Packed-BCD up/down event counter with an integrated step prescaler.
// Loads are clamped to valid BCD so bcd_out never carries a nibble above 9.
module bcd_tick_counter #(
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 500_000,
  parameter logic [4*DIGITS-1:0] INIT_VALUE = 16'h1234
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic [4*DIGITS-1:0]   stepped;
  logic                  carry_out;
  logic [4*DIGITS-1:0]   clamped;
  logic                  any_bad;
  logic                  terminal;

  assign terminal = en && (presc == PRESC_LAST);

  // Ripple carry/borrow from digit 0 upward; carry_out left set means wraparound.
  always_comb begin
    logic       c;
    logic [3:0] d;
    stepped   = bcd_out;
    c         = 1'b1;
    d         = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd_out[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d >= 4'd9) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = d;
    end
    carry_out = c;
  end

  always_comb begin
    clamped = load_value;
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) begin
        clamped[4*i +: 4] = 4'd9;
        any_bad           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out  <= INIT_VALUE;
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        bcd_out  <= clamped;
        load_err <= any_bad;
        presc    <= '0;
      end else if (terminal) begin
        presc   <= '0;
        bcd_out <= stepped;
        tick    <= 1'b1;
        wrap    <= carry_out;
      end else if (en) begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: a 4-digit/divide-by-4 instance and a 1-digit/divide-by-1
// instance run side by side against an integer-arithmetic reference model.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] lv;
  logic [15:0] bcd_out;
  logic        tick, wrap, load_err;

  logic        s_rst, s_en, s_up, s_load;
  logic [3:0]  s_lv;
  logic [3:0]  s_bcd;
  logic        s_tick, s_wrap, s_err;

  int total = 0;
  int bad = 0;

  // model state: value as a plain integer, prescale position as a count
  int mv, mc;
  bit mt, mw, me;
  int sv;
  bit st, sw, se;

  always #5 clk = ~clk;

  bcd_tick_counter #(.DIGITS(4), .TICK_DIV(4), .INIT_VALUE(16'h1234)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(lv),
    .bcd_out(bcd_out), .tick(tick), .wrap(wrap), .load_err(load_err)
  );

  bcd_tick_counter #(.DIGITS(1), .TICK_DIV(1), .INIT_VALUE(4'h7)) dut_s (
    .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load), .load_value(s_lv),
    .bcd_out(s_bcd), .tick(s_tick), .wrap(s_wrap), .load_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v, input int nd);
    logic [15:0] b;
    int x;
    b = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic int clamp_val(input logic [15:0] b, input int nd);
    int r;
    int d;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] b, input int nd);
    bit f;
    f = 1'b0;
    for (int i = 0; i < nd; i++) if (b[4*i +: 4] > 4'd9) f = 1'b1;
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk);
    mt = 0; mw = 0; me = 0;
    if (rst) begin
      mv = 1234; mc = 0;
    end else if (load) begin
      mv = clamp_val(lv, 4); me = has_bad(lv, 4); mc = 0;
    end else if (en) begin
      if (mc == 3) begin
        mc = 0; mt = 1;
        if (up) begin mw = (mv == 9999); mv = (mv + 1) % 10000; end
        else    begin mw = (mv == 0);    mv = (mv + 9999) % 10000; end
      end else begin
        mc++;
      end
    end
    st = 0; sw = 0; se = 0;
    if (s_rst) begin
      sv = 7;
    end else if (s_load) begin
      sv = clamp_val({12'h0, s_lv}, 1); se = has_bad({12'h0, s_lv}, 1);
    end else if (s_en) begin
      st = 1;
      if (s_up) begin sw = (sv == 9); sv = (sv + 1) % 10; end
      else      begin sw = (sv == 0); sv = (sv + 9) % 10; end
    end
    #1;
    chk("bcd_out", bcd_out, to_bcd(mv, 4));
    chk("tick", tick, mt);
    chk("wrap", wrap, mw);
    chk("load_err", load_err, me);
    chk("s_bcd", s_bcd, to_bcd(sv, 1));
    chk("s_tick", s_tick, st);
    chk("s_wrap", s_wrap, sw);
    chk("s_err", s_err, se);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; lv = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; lv = '0;
    s_rst = 1; s_en = 0; s_up = 1; s_load = 0; s_lv = '0;
    mv = 0; mc = 0; sv = 0;
    run(2);
    rst = 0; s_rst = 0;
    run(10);
    chk("init_hold", bcd_out, 16'h1234);

    // up count across a carry
    s_en = 1;
    do_load(16'h0098);
    en = 1; up = 1;
    run(12);
    chk("carry_end", bcd_out, 16'h0101);

    do_load(16'h9999);
    run(4);
    chk("up_wrap_val", bcd_out, 16'h0000);
    chk("up_wrap_flag", wrap, 1'b1);

    up = 0;
    do_load(16'h1000);
    run(4);
    chk("borrow_val", bcd_out, 16'h0999);
    do_load(16'h0000);
    run(4);
    chk("down_wrap_val", bcd_out, 16'h9999);
    chk("down_wrap_flag", wrap, 1'b1);

    // invalid load landing on a terminal cycle
    do_load(16'h0000);
    run(3);
    do_load(16'h1A3F);
    chk("clamp_val", bcd_out, 16'h1939);
    chk("clamp_err", load_err, 1'b1);
    chk("clamp_notick", tick, 1'b0);
    run(4);
    chk("after_load_tick", tick, 1'b1);

    // enable gating, then reset mid-period
    do_load(16'h0500);
    up = 1;
    run(2);
    en = 0; run(5);
    en = 1; run(2);
    chk("gated_tick", tick, 1'b1);
    run(3);
    rst = 1; cycle(); rst = 0;
    chk("mid_reset_val", bcd_out, 16'h1234);
    run(4);
    chk("post_reset_tick", tick, 1'b1);

    // single-digit instance wrapping both ways
    s_load = 1; s_lv = 4'h9; cycle(); s_load = 0;
    s_up = 1; cycle();
    chk("s_up_wrap", s_wrap, 1'b1);
    s_up = 0; cycle();
    chk("s_down_wrap", s_bcd, 4'h9);
    s_load = 1; s_lv = 4'hC; cycle(); s_load = 0;
    chk("s_clamp", s_bcd, 4'h9);

    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 9) < 8);
      up     = ($urandom_range(0, 19) != 0) ? up : ~up;
      load   = ($urandom_range(0, 39) == 0);
      lv     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lv = 16'h9999;
      s_rst  = ($urandom_range(0, 199) == 0);
      s_en   = ($urandom_range(0, 9) < 7);
      s_up   = 1'($urandom);
      s_load = ($urandom_range(0, 19) == 0);
      s_lv   = 4'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
Parametrised decimal (BCD) event counter with built-in tick prescaler. It succeeds the fixed 4-digit count-up display counter: digit count, prescale period and initial value are generic. It adds up/down mode, enable, synchronous load with BCD validation, and wrap/tick status pulses. It drives the 7-segment display path directly with packed BCD digits, so the display side needs no binary-to-BCD conversion.

Parameters:
DIGITS, 4, number of BCD digits (>=1); digit 0 = least significant, at bits [3:0]
TICK_DIV, 500_000, clk cycles per count step while enabled (>=1)
INIT_VALUE, 16'h1234, packed BCD value applied on reset (width 4*DIGITS; every nibble must be 0-9)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  count enable; gates both the prescaler and the stepping
up  in  1  1 = count up, 0 = count down; sampled on the step cycle
load  in  1  synchronous load strobe
load_value  in  4*DIGITS  packed BCD value to load
bcd_out  out  4*DIGITS  current count, packed BCD
tick  out  1  one-cycle pulse, coincident with each bcd_out step
wrap  out  1  one-cycle pulse when a step wraps (9..9->0..0 up, 0..0->9..9 down)
load_err  out  1  one-cycle pulse when load_value contained a nibble >9

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge): bcd_out=INIT_VALUE, prescaler=0, tick=0, wrap=0, load_err=0. Reset overrides load and en.
- Prescaler:
  - Width max(1,$clog2(TICK_DIV)); counts 0..TICK_DIV-1 while en=1; holds its value while en=0.
  - Terminal cycle: en=1 and prescaler==TICK_DIV-1. On that cycle the prescaler returns to 0 and a step occurs.
  - Step period is exactly TICK_DIV enabled cycles. TICK_DIV=1 gives a step on every enabled cycle.
- Step:
  - Up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Carry out of, or borrow from, the top digit means wraparound: wrap=1 for that cycle.
  - tick=1 in the cycle bcd_out shows the new value, i.e. the cycle after the terminal cycle. Step latency is 1 clk.
- Load (load=1, rst=0):
  - bcd_out takes load_value, with every nibble >9 clamped to 9.
  - load_err=1 next cycle if any nibble was clamped.
  - Prescaler clears to 0.
  - Load has priority over a coincident step: no tick, no wrap. Load works regardless of en.
- en=0: bcd_out, prescaler and up-direction state hold; tick/wrap stay 0.
- Direction change mid-period takes effect on the next step. The prescaler is not restarted.
- bcd_out never holds a non-BCD nibble.
- tick, wrap and load_err are each high for exactly one cycle per event, never stretched.
- Reset mid-period discards the partial prescale count.

Test Plan:
- Reset/init: DIGITS=4, TICK_DIV=4. Assert rst 2 cycles, release, hold en=0 for 10 cycles -> bcd_out=16'h1234, tick/wrap/load_err=0 throughout.
- Up count with carry: load 16'h0098, en=1, up=1 -> tick every 4th cycle. bcd_out steps 0099, 0100, 0101; wrap=0.
- Up wraparound: load 16'h9999, up=1, en=1 -> after 4 cycles bcd_out=16'h0000, tick=1 and wrap=1 in the same single cycle.
- Down borrow and wrap: load 16'h1000, up=0 -> next step gives 16'h0999. Then load 16'h0000 -> next step gives 16'h9999 with wrap=1.
- Invalid load and priority: drive load=1 with load_value=16'h1A3F on a prescaler terminal cycle -> bcd_out=16'h1939, load_err=1 for one cycle, no tick, next tick 4 enabled cycles later.
- Enable gating and reset mid-period: en=1 for 2 cycles, en=0 for 5, then en=1 -> first tick after 2 more cycles. Repeat with rst pulsed after 3 enabled cycles -> bcd_out=16'h1234, next tick after 4 full cycles. Also run with TICK_DIV=1, DIGITS=1: tick every cycle, 9->0 sets wrap.
